// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory and writeback stages of the rv32i pipeline.
// Byte/half/word loads and stores on an internal word-organised data memory,
// followed by the MEM/WB pipeline register that drives the register-file write port.
module mem_wb_stage #(
    parameter int DPW        = 32,
    parameter int ADW        = 5,
    parameter int DMEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [2:0]     funct3M,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [ADW-1:0] RdM,
    output logic           regwriteW,
    output logic [ADW-1:0] RdW,
    output logic [DPW-1:0] resultW,
    output logic           misalignW
);

    localparam int AW = $clog2(DMEM_DEPTH);

    // Data memory: not reset, contents undefined until written.
    logic [DPW-1:0] mem_r [DMEM_DEPTH];

    logic [AW-1:0]  word_idx_s;
    logic [1:0]     lane_s;
    logic           misalign_s;
    logic [DPW-1:0] rd_word_s;
    logic [7:0]     byte_s;
    logic [15:0]    half_s;
    logic [DPW-1:0] load_data_s;
    logic [3:0]     be_s;
    logic [DPW-1:0] wdata_s;

    // Upper address bits are dropped, so accesses wrap modulo 4*DMEM_DEPTH bytes.
    assign word_idx_s = aluresultM[AW+1:2];
    assign lane_s     = aluresultM[1:0];
    assign rd_word_s  = mem_r[word_idx_s];

    // Alignment check: halfwords need an even lane, words need lane 0, bytes always fit.
    always_comb begin
        misalign_s = 1'b0;
        case (funct3M)
            3'b001, 3'b101: misalign_s = lane_s[0];
            3'b010:         misalign_s = (lane_s != 2'b00);
            default:        misalign_s = 1'b0;
        endcase
    end

    // Pick the addressed byte and halfword out of the asynchronously read word.
    always_comb begin
        byte_s = 8'h00;
        case (lane_s)
            2'b00:   byte_s = rd_word_s[7:0];
            2'b01:   byte_s = rd_word_s[15:8];
            2'b10:   byte_s = rd_word_s[23:16];
            2'b11:   byte_s = rd_word_s[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane_s[1]) begin
            half_s = rd_word_s[31:16];
        end else begin
            half_s = rd_word_s[15:0];
        end
    end

    // Size/sign extension of load data; misaligned loads return zero, unknown funct3 reads as LW.
    always_comb begin
        load_data_s = {DPW{1'b0}};
        if (misalign_s) begin
            load_data_s = {DPW{1'b0}};
        end else begin
            case (funct3M)
                3'b000:  load_data_s = {{(DPW-8){byte_s[7]}}, byte_s};
                3'b100:  load_data_s = {{(DPW-8){1'b0}}, byte_s};
                3'b001:  load_data_s = {{(DPW-16){half_s[15]}}, half_s};
                3'b101:  load_data_s = {{(DPW-16){1'b0}}, half_s};
                default: load_data_s = rd_word_s;
            endcase
        end
    end

    // Store byte enables and lane-replicated write data; nothing is written in reset or when misaligned.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = Rd2M;
        if (rst_n && memwriteM && !misalign_s) begin
            case (funct3M)
                3'b000: begin
                    be_s    = 4'b0001 << lane_s;
                    wdata_s = {4{Rd2M[7:0]}};
                end
                3'b001: begin
                    be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{Rd2M[15:0]}};
                end
                3'b010: begin
                    be_s    = 4'b1111;
                    wdata_s = Rd2M;
                end
                default: begin
                    be_s    = 4'b0000;
                    wdata_s = Rd2M;
                end
            endcase
        end else begin
            be_s    = 4'b0000;
            wdata_s = Rd2M;
        end
    end

    // Byte-enabled write into the data memory; unselected bytes keep their value.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
                mem_r[word_idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
            end
        end
    end

    // MEM/WB pipeline register; a misaligned load never writes the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwriteW <= 1'b0;
            RdW       <= {ADW{1'b0}};
            resultW   <= {DPW{1'b0}};
            misalignW <= 1'b0;
        end else begin
            regwriteW <= regwriteM & ~(resultsrcM & misalign_s);
            RdW       <= RdM;
            resultW   <= resultsrcM ? load_data_s : aluresultM;
            misalignW <= (memwriteM | resultsrcM) & misalign_s;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed stimulus for mem_wb_stage, checked every
// cycle against a byte-addressed behavioural model, plus literal expectations.
module tb_mem_wb_stage;

    localparam int DEPTH = 256;
    localparam int BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        regwriteM = 1'b0;
    logic        resultsrcM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [2:0]  funct3M = 3'b000;
    logic [31:0] aluresultM = 32'h0;
    logic [31:0] Rd2M = 32'h0;
    logic [4:0]  RdM = 5'd0;
    logic        regwriteW;
    logic [4:0]  RdW;
    logic [31:0] resultW;
    logic        misalignW;

    int n_vec = 0;
    int n_err = 0;

    mem_wb_stage #(.DPW(32), .ADW(5), .DMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
        .memwriteM(memwriteM), .funct3M(funct3M), .aluresultM(aluresultM), .Rd2M(Rd2M),
        .RdM(RdM), .regwriteW(regwriteW), .RdW(RdW), .resultW(resultW), .misalignW(misalignW)
    );

    always #5 clk = ~clk;

    // Behavioural model: byte array memory and expected W outputs.
    logic [7:0]  mem_m [BYTES];
    logic        exp_valid = 1'b0;
    logic        exp_rw, exp_mis;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;

    always @(posedge clk) begin
        int a, base, sz, v;
        bit mis;
        logic [31:0] ld;
        if (!rst_n) begin
            exp_rw = 1'b0; exp_rd = 5'd0; exp_res = 32'h0; exp_mis = 1'b0;
        end else begin
            a = int'(aluresultM % BYTES);
            base = a - (a % 4);
            case (funct3M)
                3'b001, 3'b101: sz = 2;
                3'b010:         sz = 4;
                default:        sz = 1;
            endcase
            mis = (a % sz) != 0;
            case (funct3M)
                3'b000: begin v = int'(mem_m[a]); if (v > 127) v = v - 256; end
                3'b100: v = int'(mem_m[a]);
                3'b001: begin
                    v = int'(mem_m[a]) + 256 * int'(mem_m[(a + 1) % BYTES]);
                    if (v > 32767) v = v - 65536;
                end
                3'b101: v = int'(mem_m[a]) + 256 * int'(mem_m[(a + 1) % BYTES]);
                default: v = int'({mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]});
            endcase
            ld = mis ? 32'h0 : v[31:0];
            // Load value is taken before this edge's store lands.
            if (memwriteM && !mis) begin
                case (funct3M)
                    3'b000: mem_m[a] = Rd2M[7:0];
                    3'b001: begin mem_m[a] = Rd2M[7:0]; mem_m[a+1] = Rd2M[15:8]; end
                    3'b010: for (int k = 0; k < 4; k++) mem_m[base+k] = Rd2M[8*k +: 8];
                    default: ;
                endcase
            end
            exp_rw  = regwriteM & ~(resultsrcM & mis);
            exp_rd  = RdM;
            exp_res = resultsrcM ? ld : aluresultM;
            exp_mis = (memwriteM | resultsrcM) & mis;
        end
        exp_valid = 1'b1;
    end

    // Per-cycle compare of every W output against the model.
    always @(negedge clk) begin
        if (exp_valid) begin
            n_vec++;
            if (regwriteW !== exp_rw) begin
                n_err++; $display("FAIL cyc regwriteW: got %b expected %b @%0t", regwriteW, exp_rw, $time);
            end
            n_vec++;
            if (RdW !== exp_rd) begin
                n_err++; $display("FAIL cyc RdW: got %0d expected %0d @%0t", RdW, exp_rd, $time);
            end
            n_vec++;
            if (resultW !== exp_res) begin
                n_err++; $display("FAIL cyc resultW: got %h expected %h @%0t", resultW, exp_res, $time);
            end
            n_vec++;
            if (misalignW !== exp_mis) begin
                n_err++; $display("FAIL cyc misalignW: got %b expected %b @%0t", misalignW, exp_mis, $time);
            end
        end
    end

    task automatic op(input logic rst, input logic rw, input logic rs, input logic mw,
                      input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd);
        @(negedge clk);
        rst_n = rst; regwriteM = rw; resultsrcM = rs; memwriteM = mw;
        funct3M = f3; aluresultM = addr; Rd2M = wd; RdM = rd;
    endtask

    // Hand-computed expectation for the instruction just issued, checked after its edge.
    task automatic lit(input string nm, input logic rw, input logic [4:0] rd,
                       input logic [31:0] res, input logic mis);
        @(posedge clk);
        #1;
        n_vec++;
        if ({regwriteW, RdW, resultW, misalignW} !== {rw, rd, res, mis}) begin
            n_err++;
            $display("FAIL %s: got rw=%b rd=%0d res=%h mis=%b, expected rw=%b rd=%0d res=%h mis=%b",
                     nm, regwriteW, RdW, resultW, misalignW, rw, rd, res, mis);
        end
        n_vec++;
        if ({exp_rw, exp_rd, exp_res, exp_mis} !== {rw, rd, res, mis}) begin
            n_err++;
            $display("FAIL %s-model: model res=%h rw=%b, expected res=%h rw=%b", nm, exp_res, exp_rw, res, rw);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] addr;
        // Reset and store-suppression during reset
        op(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 5'd1);
        op(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h22222222, 5'd2);
        op(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, 5'd3);
        lit("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd4);
        lit("reset_store_suppressed", 1'b1, 5'd4, 32'h22222222, 1'b0);

        // Fill the whole memory so every later load is defined
        for (int i = 0; i < DEPTH; i++)
            op(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, i * 4, $urandom, 5'd0);

        // Store then load the same word on the next cycle
        op(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5);
        lit("sw_lw", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);

        // Byte store and loads
        op(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h13, 32'hAAAAAA80, 5'd0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd6);
        lit("lb", 1'b1, 5'd6, 32'hFFFFFF80, 1'b0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 5'd6);
        lit("lbu", 1'b1, 5'd6, 32'h00000080, 1'b0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd6);
        lit("lw_after_sb", 1'b1, 5'd6, 32'h80ADBEEF, 1'b0);

        // Halfword store/loads and misaligned word access
        op(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'h12, 32'h55558234, 5'd0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 5'd8);
        lit("lh", 1'b1, 5'd8, 32'hFFFF8234, 1'b0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 5'd8);
        lit("lhu", 1'b1, 5'd8, 32'h00008234, 1'b0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 5'd9);
        lit("lw_misaligned", 1'b0, 5'd9, 32'h0, 1'b1);
        op(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h11, 32'h12345678, 5'd0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd9);
        lit("sw_misaligned_no_write", 1'b1, 5'd9, 32'h8234BEEF, 1'b0);

        // ALU writeback path
        op(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h00000055, 32'h0, 5'd7);
        lit("alu_path", 1'b1, 5'd7, 32'h00000055, 1'b0);

        // Address wrap at 4*DEPTH bytes
        op(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd0);
        op(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h000, 32'h0, 5'd10);
        lit("wrap", 1'b1, 5'd10, 32'hCAFEF00D, 1'b0);

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 3000; i++) begin
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                addr = $urandom;
            else
                addr = 32'($urandom_range(0, 63));
            op(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               f3, addr, $urandom, 5'($urandom));
        end

        op(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
